// File: rtl/ib_debounce_counter.sv
`default_nettype none
// ============================================================================
// Module   : ib_debounce_counter
// Purpose  : Consumer stage for an input-buffer pad level. Synchronises the
//            raw level, debounces it, emits a one-cycle pulse on every
//            debounced rising edge, and counts those edges in a wrapping
//            counter. The design uses plain LUT/DFF logic only.
// Ports    : C    in   clock, all flops on rising edge
//            R    in   synchronous active-high reset
//            I    in   raw pad level, asynchronous to C
//            CLR  in   synchronous clear of Q (and OVF)
//            S    out  debounced stable level
//            P    out  one-cycle pulse on debounced rising edge
//            Q    out  COUNT_W-bit rising-edge event count, wraps
//            OVF  out  sticky wrap flag
// Options  : IB_DBNC_OVF_EN - when defined, OVF is a sticky flop set on
//            each wrap of Q; when undefined, OVF is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module ib_debounce_counter #(
  parameter int SYNC_STAGES = 2,  // 2..4
  parameter int DBNC_CYCLES = 4,  // 1..255
  parameter int COUNT_W     = 4   // 1..16
) (
  input  logic               C,
  input  logic               R,
  input  logic               I,
  input  logic               CLR,
  output logic               S,
  output logic               P,
  output logic [COUNT_W-1:0] Q,
  output logic               OVF
);

  // --------------------------------------------------------------------------
  // Constants and types
  // --------------------------------------------------------------------------
  localparam int                 c_CNT_W = 8;
  localparam logic [c_CNT_W-1:0] c_DBNC  = c_CNT_W'(DBNC_CYCLES);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
  localparam logic [COUNT_W-1:0] c_Q_ONE = COUNT_W'(1);

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    ST_L2H = 2'd1,
    ST_HI  = 2'd2,
    ST_H2L = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_synced;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_CNT_W-1:0]     w_cnt_nxt;
  logic [c_CNT_W-1:0]     w_cnt_inc;
  logic                   w_done;
  logic                   r_s;
  logic                   w_s_nxt;
  logic                   w_rise;
  logic                   r_p;
  logic [COUNT_W-1:0]     r_q;

  // --------------------------------------------------------------------------
  // Synchroniser: sy[0] takes I, each later stage takes its predecessor.
  // --------------------------------------------------------------------------
  always_ff @(posedge C) begin
    if (R) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], I};
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Debounce FSM - state register
  // --------------------------------------------------------------------------
  always_ff @(posedge C) begin
    if (R) begin
      r_state <= ST_LO;
      r_cnt   <= '0;
      r_s     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_s     <= w_s_nxt;
    end
  end

  // r_cnt holds the number of differing samples already accepted; it is
  // always 0 in the stable states. The compare uses the count including
  // the sample seen this cycle, so S flips on the DBNC_CYCLES-th differing
  // sample. With DBNC_CYCLES=1 this fires straight from a stable state and
  // the transient state is never entered.
  assign w_cnt_inc = r_cnt + c_ONE;
  assign w_done    = (w_cnt_inc == c_DBNC);

  // --------------------------------------------------------------------------
  // Debounce FSM - next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_s_nxt     = r_s;
    w_rise      = 1'b0;
    case (r_state)
      ST_LO: begin
        if (w_synced) begin
          if (w_done) begin
            w_state_nxt = ST_HI;
            w_cnt_nxt   = '0;
            w_s_nxt     = 1'b1;
            w_rise      = 1'b1;
          end else begin
            w_state_nxt = ST_L2H;
            w_cnt_nxt   = w_cnt_inc;
          end
        end
      end
      ST_L2H: begin
        if (!w_synced) begin
          // Glitch: fall back and forget the partial count.
          w_state_nxt = ST_LO;
          w_cnt_nxt   = '0;
        end else if (w_done) begin
          w_state_nxt = ST_HI;
          w_cnt_nxt   = '0;
          w_s_nxt     = 1'b1;
          w_rise      = 1'b1;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      ST_HI: begin
        if (!w_synced) begin
          if (w_done) begin
            w_state_nxt = ST_LO;
            w_cnt_nxt   = '0;
            w_s_nxt     = 1'b0;
          end else begin
            w_state_nxt = ST_H2L;
            w_cnt_nxt   = w_cnt_inc;
          end
        end
      end
      ST_H2L: begin
        if (w_synced) begin
          w_state_nxt = ST_HI;
          w_cnt_nxt   = '0;
        end else if (w_done) begin
          w_state_nxt = ST_LO;
          w_cnt_nxt   = '0;
          w_s_nxt     = 1'b0;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_LO;
        w_cnt_nxt   = '0;
        w_s_nxt     = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Rising-edge pulse and event counter. Both update on the edge where S
  // becomes 1, so P, S and the new Q value appear together.
  // --------------------------------------------------------------------------
  always_ff @(posedge C) begin
    if (R) begin
      r_p <= 1'b0;
    end else begin
      r_p <= w_rise;
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      r_q <= '0;
    end else if (CLR) begin
      // Clear beats a coincident event; that event is dropped.
      r_q <= '0;
    end else if (w_rise) begin
      r_q <= r_q + c_Q_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Optional sticky wrap flag
  // --------------------------------------------------------------------------
`ifdef IB_DBNC_OVF_EN
  logic r_ovf;
  logic w_q_max;

  assign w_q_max = &r_q;

  always_ff @(posedge C) begin
    if (R) begin
      r_ovf <= 1'b0;
    end else if (CLR) begin
      r_ovf <= 1'b0;
    end else if (w_rise && w_q_max) begin
      r_ovf <= 1'b1;
    end
  end

  assign OVF = r_ovf;
`else
  assign OVF = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs - all straight from flops
  // --------------------------------------------------------------------------
  assign S = r_s;
  assign P = r_p;
  assign Q = r_q;

endmodule
`default_nettype wire

// File: tb/tb_ib_debounce_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ib_debounce_counter
// Purpose  : Directed self-checking bench for ib_debounce_counter at the
//            default parameters (SYNC_STAGES=2, DBNC_CYCLES=4, COUNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ib_debounce_counter;

  logic       C;
  logic       R;
  logic       I;
  logic       CLR;
  logic       S;
  logic       P;
  logic [3:0] Q;
  logic       OVF;

  int passed;
  int failed;
  int total;

  logic c_ovf_wrap;

  ib_debounce_counter #(
    .SYNC_STAGES(2),
    .DBNC_CYCLES(4),
    .COUNT_W    (4)
  ) dut (
    .C  (C),
    .R  (R),
    .I  (I),
    .CLR(CLR),
    .S  (S),
    .P  (P),
    .Q  (Q),
    .OVF(OVF)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // Advance n rising edges, ending 1 time unit after the last one.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge C);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clean press/release; S rises on edge 6 after I goes high.
  task automatic press(input logic [3:0] exp_q);
    I = 1'b1;
    tick(5);
    chk("press_s_pre", 32'(S), 32'd0);
    tick(1);
    chk("press_s", 32'(S), 32'd1);
    chk("press_p", 32'(P), 32'd1);
    chk("press_q", 32'(Q), 32'(exp_q));
    I = 1'b0;
    tick(7);
    chk("release_s", 32'(S), 32'd0);
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
`ifdef IB_DBNC_OVF_EN
    c_ovf_wrap = 1'b1;
`else
    c_ovf_wrap = 1'b0;
`endif
    R   = 1'b1;
    I   = 1'b1;
    CLR = 1'b0;

    // 1. Reset with I held high.
    tick(3);
    chk("rst_s",   32'(S),   32'd0);
    chk("rst_p",   32'(P),   32'd0);
    chk("rst_q",   32'(Q),   32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    R = 1'b0;
    tick(5);
    chk("rst_s_e5", 32'(S), 32'd0);
    tick(1);
    chk("rst_s_e6", 32'(S), 32'd1);
    chk("rst_p_e6", 32'(P), 32'd1);
    chk("rst_q_e6", 32'(Q), 32'd1);
    tick(1);
    chk("rst_p_e7", 32'(P), 32'd0);

    // 2. Release, then a clean press.
    I = 1'b0;
    tick(5);
    chk("fall_s_e5", 32'(S), 32'd1);
    tick(1);
    chk("fall_s_e6", 32'(S), 32'd0);
    chk("fall_p_e6", 32'(P), 32'd0);
    tick(2);
    chk("fall_p_after", 32'(P), 32'd0);
    chk("fall_q", 32'(Q), 32'd1);
    press(4'd2);

    // 3. Glitch of 3 synced samples is rejected.
    I = 1'b1;
    tick(3);
    I = 1'b0;
    tick(10);
    chk("glitch_s", 32'(S), 32'd0);
    chk("glitch_q", 32'(Q), 32'd2);
    // Exactly 4 synced samples is accepted.
    I = 1'b1;
    tick(4);
    I = 1'b0;
    tick(1);
    chk("four_s_e5", 32'(S), 32'd0);
    tick(1);
    chk("four_s_e6", 32'(S), 32'd1);
    chk("four_p_e6", 32'(P), 32'd1);
    chk("four_q_e6", 32'(Q), 32'd3);
    tick(4);
    chk("four_s_fall", 32'(S), 32'd0);
    tick(2);

    // 4. Wrap: clear then 16 presses.
    CLR = 1'b1;
    tick(1);
    CLR = 1'b0;
    chk("clr_q", 32'(Q), 32'd0);
    chk("clr_s", 32'(S), 32'd0);
    for (int n = 1; n <= 16; n++) begin
      press(4'(n));
      if (n == 15) chk("pre_wrap_ovf", 32'(OVF), 32'd0);
    end
    chk("wrap_q",   32'(Q),   32'd0);
    chk("wrap_ovf", 32'(OVF), 32'(c_ovf_wrap));

    // 5. CLR collides with the event edge while Q=5.
    for (int n = 1; n <= 5; n++) press(4'(n));
    chk("coll_q_pre", 32'(Q), 32'd5);
    I = 1'b1;
    tick(5);
    CLR = 1'b1;
    tick(1);
    CLR = 1'b0;
    chk("coll_q",   32'(Q),   32'd0);
    chk("coll_s",   32'(S),   32'd1);
    chk("coll_p",   32'(P),   32'd1);
    chk("coll_ovf", 32'(OVF), 32'd0);
    I = 1'b0;
    tick(7);
    chk("coll_rel_s", 32'(S), 32'd0);

    // 6. Reset in the middle of a debounce (L2H, count 2).
    I = 1'b1;
    tick(4);
    R = 1'b1;
    tick(1);
    R = 1'b0;
    chk("mid_s",   32'(S),   32'd0);
    chk("mid_p",   32'(P),   32'd0);
    chk("mid_q",   32'(Q),   32'd0);
    chk("mid_ovf", 32'(OVF), 32'd0);
    tick(5);
    chk("mid_s_e5", 32'(S), 32'd0);
    tick(1);
    chk("mid_s_e6", 32'(S), 32'd1);
    chk("mid_q_e6", 32'(Q), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
